// File: rtl/wb_completion_buffer_pkg.sv
// Shared definitions for the writeback completion buffer: channel indices and entry layout.
// No logic; types and a channel wrap helper only.
// Imported by the top level.
package wb_completion_buffer_pkg;

    localparam int unsigned NUM_CH     = 3;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WB_ENTRY_W = REG_W + DATA_W;

    typedef logic [1:0] ch_idx_t;

    localparam ch_idx_t CH_MUL = 2'd0;
    localparam ch_idx_t CH_AM  = 2'd1;
    localparam ch_idx_t CH_MEM = 2'd2;

    typedef struct packed {
        logic [REG_W-1:0]  regdest;
        logic [DATA_W-1:0] wbvalue;
    } wb_entry_t;

    function automatic ch_idx_t ch_wrap(input int unsigned i);
        return ch_idx_t'(i % NUM_CH);
    endfunction

endpackage

// File: rtl/wb_completion_buffer_if.sv
// Bundle of functional-unit result buses and register-file write / Issue feedback signals.
// Pure wiring, no latency.
// Stall flows back to Issue; the units themselves cannot be stalled.
interface wb_completion_buffer_if;

    logic        mul_wb_oper;
    logic [4:0]  mul_wb_regdest;
    logic        mul_wb_writereg;
    logic [31:0] mul_wb_wbvalue;

    logic        am_wb_oper;
    logic [4:0]  am_wb_regdest;
    logic        am_wb_writereg;
    logic [31:0] am_wb_wbvalue;

    logic        mem_wb_oper;
    logic [4:0]  mem_wb_regdest;
    logic        mem_wb_writereg;
    logic [31:0] mem_wb_wbvalue;

    logic        wb_reg_en;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_reg_data;
    logic        wb_iss_stall;
    logic        wb_overflow;
    logic [5:0]  wb_occupancy;

    modport slave (
        input  mul_wb_oper, mul_wb_regdest, mul_wb_writereg, mul_wb_wbvalue,
        input  am_wb_oper,  am_wb_regdest,  am_wb_writereg,  am_wb_wbvalue,
        input  mem_wb_oper, mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue,
        output wb_reg_en, wb_reg_addr, wb_reg_data,
        output wb_iss_stall, wb_overflow, wb_occupancy
    );

    modport master (
        output mul_wb_oper, mul_wb_regdest, mul_wb_writereg, mul_wb_wbvalue,
        output am_wb_oper,  am_wb_regdest,  am_wb_writereg,  am_wb_wbvalue,
        output mem_wb_oper, mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue,
        input  wb_reg_en, wb_reg_addr, wb_reg_data,
        input  wb_iss_stall, wb_overflow, wb_occupancy
    );

endinterface

// File: rtl/wb_completion_buffer_fifo.sv
// Generic synchronous FIFO holding one unit's pending results.
// Head visible combinationally; a push becomes poppable one edge later (no bypass).
// Push into a full FIFO is accepted only when a pop happens on the same edge.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 37
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           push_dat,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset: only slots below count are ever observed.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/wb_completion_buffer.sv
// Collects up to three FU results per cycle into per-unit FIFOs and retires one per cycle round-robin.
// Latency: minimum 1 cycle from push edge to registered register-file write.
// Backpressure: combinational stall to Issue when any FIFO's free slots drop to STALL_THRESH.
module wb_completion_buffer
    import wb_completion_buffer_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STALL_THRESH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    wb_completion_buffer_if.slave wb
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0] push_vld;
    logic [NUM_CH-1:0] pop_vld;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] drop;
    wb_entry_t         push_dat [NUM_CH];
    wb_entry_t         head_dat [NUM_CH];
    logic [CNT_W-1:0]  count    [NUM_CH];

    ch_idx_t     rr_last;
    ch_idx_t     grant_idx;
    ch_idx_t     cand;
    logic        grant_vld;
    wb_entry_t   grant_dat;
    logic        stall;
    logic [5:0]  occupancy;
    logic        reg_en;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        overflow;

    // Stores and writes to x0 never occupy a slot.
    assign push_vld[CH_MUL] = wb.mul_wb_oper && wb.mul_wb_writereg && (wb.mul_wb_regdest != 5'd0);
    assign push_vld[CH_AM]  = wb.am_wb_oper  && wb.am_wb_writereg  && (wb.am_wb_regdest  != 5'd0);
    assign push_vld[CH_MEM] = wb.mem_wb_oper && wb.mem_wb_writereg && (wb.mem_wb_regdest != 5'd0);

    assign push_dat[CH_MUL] = '{regdest: wb.mul_wb_regdest, wbvalue: wb.mul_wb_wbvalue};
    assign push_dat[CH_AM]  = '{regdest: wb.am_wb_regdest,  wbvalue: wb.am_wb_wbvalue};
    assign push_dat[CH_MEM] = '{regdest: wb.mem_wb_regdest, wbvalue: wb.mem_wb_wbvalue};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
        wb_fifo #(
            .DEPTH (DEPTH),
            .W     (WB_ENTRY_W)
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .push     (push_vld[i]),
            .pop      (pop_vld[i]),
            .push_dat (push_dat[i]),
            .head     (head_dat[i]),
            .count    (count[i]),
            .full     (full[i]),
            .empty    (empty[i])
        );
    end

    // Search starts one past the last winner so every channel is served within NUM_CH grants.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_last;
        cand      = rr_last;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = ch_wrap(32'(rr_last) + k);
            if (!grant_vld && !empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        pop_vld   = '0;
        drop      = '0;
        grant_dat = '0;
        stall     = 1'b0;
        occupancy = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pop_vld[i] = grant_vld && (grant_idx == ch_idx_t'(i));
            drop[i]    = push_vld[i] && full[i] && !pop_vld[i];
            if (pop_vld[i]) grant_dat = head_dat[i];
            if ((DEPTH - 32'(count[i])) <= STALL_THRESH) stall = 1'b1;
            occupancy = occupancy + 6'(count[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg_en   <= 1'b0;
            reg_addr <= '0;
            reg_data <= '0;
            rr_last  <= CH_MEM;
            overflow <= 1'b0;
        end else begin
            reg_en <= grant_vld;
            if (grant_vld) begin
                reg_addr <= grant_dat.regdest;
                reg_data <= grant_dat.wbvalue;
                rr_last  <= grant_idx;
            end
            if (|drop) overflow <= 1'b1;
        end
    end

    assign wb.wb_reg_en    = reg_en;
    assign wb.wb_reg_addr  = reg_addr;
    assign wb.wb_reg_data  = reg_data;
    assign wb.wb_iss_stall = stall;
    assign wb.wb_overflow  = overflow;
    assign wb.wb_occupancy = occupancy;

endmodule

// File: tb/tb_wb_completion_buffer.sv
// Scoreboard bench for wb_completion_buffer: stimulus queues expected writes, a monitor retires them.
// Expected writes carry the clock edge at which they must appear.
// Directed checks cover stall, overflow, occupancy and reset behaviour.
module tb_wb_completion_buffer;

    logic clock;
    logic reset;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q [$];

    wb_completion_buffer_if wb_if ();

    wb_completion_buffer #(
        .DEPTH        (4),
        .STALL_THRESH (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .wb    (wb_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every asserted write enable must match the head of the expected queue.
    always @(negedge clock) begin
        if (wb_if.wb_reg_en === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h at edge %0d, required no write",
                         wb_if.wb_reg_addr, wb_if.wb_reg_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (wb_if.wb_reg_addr !== e.addr || wb_if.wb_reg_data !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL write_match: got addr=%0d data=%h edge=%0d, required addr=%0d data=%h edge=%0d",
                             wb_if.wb_reg_addr, wb_if.wb_reg_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data, input int at);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic set_ch(input int ch, input logic oper, input logic writereg,
                          input logic [4:0] rd, input logic [31:0] v);
        case (ch)
            0: begin
                wb_if.mul_wb_oper = oper; wb_if.mul_wb_writereg = writereg;
                wb_if.mul_wb_regdest = rd; wb_if.mul_wb_wbvalue = v;
            end
            1: begin
                wb_if.am_wb_oper = oper; wb_if.am_wb_writereg = writereg;
                wb_if.am_wb_regdest = rd; wb_if.am_wb_wbvalue = v;
            end
            default: begin
                wb_if.mem_wb_oper = oper; wb_if.mem_wb_writereg = writereg;
                wb_if.mem_wb_regdest = rd; wb_if.mem_wb_wbvalue = v;
            end
        endcase
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < 3; c++) set_ch(c, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clock);
            n++;
        end
        repeat (3) @(posedge clock);
        #1;
        chk({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int base;
        int idx;

        clear_inputs();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_reg_en",    wb_if.wb_reg_en,    0);
        chk("rst_reg_addr",  wb_if.wb_reg_addr,  0);
        chk("rst_reg_data",  wb_if.wb_reg_data,  0);
        chk("rst_overflow",  wb_if.wb_overflow,  0);
        chk("rst_occupancy", wb_if.wb_occupancy, 0);
        chk("rst_stall",     wb_if.wb_iss_stall, 0);
        reset = 1'b1;

        // Single am result: write visible only during the cycle after the push edge.
        base = cyc;
        set_ch(1, 1'b1, 1'b1, 5'd5, 32'h1234);
        expect_wr(5'd5, 32'h1234, base + 2);
        step();
        clear_inputs();
        chk("single_occupancy", wb_if.wb_occupancy, 1);
        wait_drain("single");

        // Simultaneous arrival on all channels retires mul, am, mem in that order.
        do_reset();
        base = cyc;
        set_ch(0, 1'b1, 1'b1, 5'd1, 32'hA);
        set_ch(1, 1'b1, 1'b1, 5'd2, 32'hB);
        set_ch(2, 1'b1, 1'b1, 5'd3, 32'hC);
        expect_wr(5'd1, 32'hA, base + 2);
        expect_wr(5'd2, 32'hB, base + 3);
        expect_wr(5'd3, 32'hC, base + 4);
        step();
        clear_inputs();
        chk("simul_occupancy", wb_if.wb_occupancy, 3);
        wait_drain("simul");

        // Filtered results: store, x0 destination, and no-oper never take a slot.
        do_reset();
        set_ch(0, 1'b1, 1'b1, 5'd0, 32'hFF);
        set_ch(1, 1'b1, 1'b0, 5'd5, 32'hFF);
        set_ch(2, 1'b0, 1'b1, 5'd3, 32'hFF);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("filter_occupancy", wb_if.wb_occupancy, 0);
        end
        clear_inputs();
        wait_drain("filter");

        // All three channels push on six consecutive edges: mem overflows on edge 6.
        do_reset();
        base = cyc;
        idx  = 0;
        for (int i = 1; i <= 6; i++) begin
            expect_wr(5'(i), 32'h100 + i, base + 2 + idx); idx++;
            expect_wr(5'(i + 7), 32'h200 + i, base + 2 + idx); idx++;
            if (i < 6) begin
                expect_wr(5'(i + 15), 32'h300 + i, base + 2 + idx); idx++;
            end
        end
        for (int e = 1; e <= 6; e++) begin
            set_ch(0, 1'b1, 1'b1, 5'(e), 32'h100 + e);
            set_ch(1, 1'b1, 1'b1, 5'(e + 7), 32'h200 + e);
            set_ch(2, 1'b1, 1'b1, 5'(e + 15), 32'h300 + e);
            step();
            if (e == 1) chk("fill_stall_e1", wb_if.wb_iss_stall, 0);
            if (e == 2) chk("fill_stall_e2", wb_if.wb_iss_stall, 1);
            if (e == 5) begin
                chk("fill_ovf_e5", wb_if.wb_overflow, 0);
                chk("fill_occ_e5", wb_if.wb_occupancy, 11);
            end
            if (e == 6) begin
                chk("fill_ovf_e6", wb_if.wb_overflow, 1);
                chk("fill_occ_e6", wb_if.wb_occupancy, 12);
            end
        end
        clear_inputs();
        wait_drain("fill");
        chk("fill_ovf_sticky", wb_if.wb_overflow, 1);
        chk("fill_occ_empty",  wb_if.wb_occupancy, 0);
        chk("fill_stall_low",  wb_if.wb_iss_stall, 0);
        do_reset();
        chk("fill_ovf_cleared", wb_if.wb_overflow, 0);

        // mul and am push for seven edges: am is full and granted on edge 7, nothing lost.
        do_reset();
        base = cyc;
        for (int i = 1; i <= 7; i++) begin
            expect_wr(5'(i), 32'h400 + i, base + 2 + 2 * (i - 1));
            expect_wr(5'(i + 7), 32'h500 + i, base + 3 + 2 * (i - 1));
        end
        for (int e = 1; e <= 7; e++) begin
            set_ch(0, 1'b1, 1'b1, 5'(e), 32'h400 + e);
            set_ch(1, 1'b1, 1'b1, 5'(e + 7), 32'h500 + e);
            step();
            if (e == 6) chk("fullpop_occ_e6", wb_if.wb_occupancy, 7);
            if (e == 7) begin
                chk("fullpop_occ_e7", wb_if.wb_occupancy, 8);
                chk("fullpop_ovf_e7", wb_if.wb_overflow, 0);
                chk("fullpop_stall",  wb_if.wb_iss_stall, 1);
            end
        end
        clear_inputs();
        wait_drain("fullpop");
        chk("fullpop_ovf_end", wb_if.wb_overflow, 0);

        // Reset mid-drain with three results still buffered.
        do_reset();
        base = cyc;
        set_ch(0, 1'b1, 1'b1, 5'd1, 32'hA);
        set_ch(1, 1'b1, 1'b1, 5'd2, 32'hB);
        set_ch(2, 1'b1, 1'b1, 5'd3, 32'hC);
        expect_wr(5'd1, 32'hA, base + 2);
        step();
        clear_inputs();
        set_ch(0, 1'b1, 1'b1, 5'd4, 32'hD);
        step();
        clear_inputs();
        chk("middrain_occ", wb_if.wb_occupancy, 3);
        chk("middrain_en",  wb_if.wb_reg_en, 1);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("middrain_rst_en",   wb_if.wb_reg_en,    0);
        chk("middrain_rst_addr", wb_if.wb_reg_addr,  0);
        chk("middrain_rst_data", wb_if.wb_reg_data,  0);
        chk("middrain_rst_occ",  wb_if.wb_occupancy, 0);
        chk("middrain_rst_stall", wb_if.wb_iss_stall, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (4) step();
        chk("middrain_no_writes", exp_q.size(), 0);
        // mul wins over am again only if the arbiter pointer was restored.
        base = cyc;
        set_ch(0, 1'b1, 1'b1, 5'd7, 32'h77);
        set_ch(1, 1'b1, 1'b1, 5'd8, 32'h88);
        expect_wr(5'd7, 32'h77, base + 2);
        expect_wr(5'd8, 32'h88, base + 3);
        step();
        clear_inputs();
        wait_drain("rr_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_completion_buffer.md
# wb_completion_buffer

Result-completion stage between the three functional units (Mult, AluMisc, Mem) and the single register-file write port. Accepts up to three results per cycle, holds them in per-unit FIFOs, and drains one per cycle by round-robin arbitration. Drives the register-file write port and sends back-pressure to Issue so that the functional-unit pipelines, which cannot stall, never overflow it.

## Interface
Parameters:
- DEPTH, 4: entries per unit FIFO; power of two, minimum 2.
- STALL_THRESH, 2: free slots per FIFO at or below which Issue is stalled.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- mul_wb_oper / am_wb_oper / mem_wb_oper  in  1 each  result valid from that unit this cycle.
- mul_wb_regdest / am_wb_regdest / mem_wb_regdest  in  5 each  destination register.
- mul_wb_writereg / am_wb_writereg / mem_wb_writereg  in  1 each  result writes a register.
- mul_wb_wbvalue / am_wb_wbvalue / mem_wb_wbvalue  in  32 each  result data.
- wb_reg_en  out  1  register-file write enable (registered).
- wb_reg_addr  out  5  write address (registered).
- wb_reg_data  out  32  write data (registered).
- wb_iss_stall  out  1  combinational back-pressure to Issue.
- wb_overflow  out  1  sticky error flag, set by a dropped result.
- wb_occupancy  out  6  total entries held across all three FIFOs, for debug.

## Operation
- Channel index: 0 = mul, 1 = am, 2 = mem.
- Input filter: a result is pushed only when oper=1, writereg=1 and regdest≠0. Results failing the filter are discarded and take no slot. Stores and writes to x0 are discarded this way.
- Push: each FIFO entry holds {regdest, wbvalue}. All three channels can push in the same cycle.
- Arbitration: among non-empty FIFOs, grant the first one found searching cyclically from rr_last+1. After a grant, rr_last is updated to the granted index. If no FIFO is non-empty, rr_last is unchanged.
- Pop: the granted FIFO pops its head. On the next edge the head is registered onto wb_reg_en=1, wb_reg_addr and wb_reg_data. If nothing is granted, wb_reg_en=0 and addr/data hold their previous values.
- Full FIFO:
  - Push and pop in the same cycle: the push is accepted and the count is unchanged.
  - Push with no pop: the result is dropped, wb_overflow is set to 1 and held until reset, and the FIFO contents are unchanged.
- Empty FIFO: never granted. A push into an empty FIFO cannot be popped in the same cycle (no bypass).
- wb_iss_stall = 1 when any FIFO has free slots ≤ STALL_THRESH, where free slots = DEPTH − count. STALL_THRESH covers the results still in flight in the unit pipelines.
- Ordering: results are in order within a channel only; there is no ordering across channels. WAW hazards remain Issue's responsibility.

## Timing
- Reset values:
  - wb_reg_en=0, wb_reg_addr=0, wb_reg_data=0.
  - All FIFO counts 0, all read/write pointers 0.
  - rr_last=2, so mul has priority on the first arbitration.
  - wb_overflow=0, wb_occupancy=0, wb_iss_stall=0.
- Latency: a result pushed at edge N is written to the register file no earlier than edge N+1, with wb_reg_en high during cycle N+1 to N+2. Minimum latency is 1 cycle. Worst-case latency under continuous traffic on all channels is 3·DEPTH cycles.
- Throughput: one register write per cycle.
- FIFO pointers wrap modulo DEPTH. Counts run 0 to DEPTH.
- wb_occupancy = sum of the three counts, registered with the counts.
- Reset asserted mid-operation: all buffered results are lost, outputs go to their reset values asynchronously, and no write-enable pulse is generated after reset deasserts.
- The register file's write-before-read behaviour is unchanged by this block.

## Structure
- Shared package (mips_pkg, or the common defines header): channel index constants CH_MUL/CH_AM/CH_MEM, NUM_CH=3, and the wb entry width (5+32).
- Sub-module wb_fifo: parameterised synchronous FIFO with push, pop, head, count, full, empty and the same asynchronous active-low reset. It is instantiated three times.
- Top-level logic: input filter, round-robin arbiter, output register, stall/overflow/occupancy logic.
- wb_completion_buffer replaces Writeback in the Mips top level. wb_iss_stall is ORed into Issue's stall.

## Test plan
- Single result: am pushes regdest=5, value=0x1234 at edge 1 → wb_reg_en=1, addr=5, data=0x1234 in cycle 2 only.
- Simultaneous arrival: mul, am and mem push regdests 1, 2, 3 with values 0xA, 0xB, 0xC in one cycle after reset → writes in the order mul, am, mem on three consecutive cycles.
- Filtering: pushes with writereg=0, or with regdest=0, value=0xFF → wb_reg_en never asserts and wb_occupancy stays 0.
- Fill and overflow (DEPTH=4, STALL_THRESH=2), mem pushing every cycle while am holds the grant:
  - wb_iss_stall rises when mem count reaches 2.
  - A 5th push with no pop → wb_overflow=1, held until reset.
  - The 4 held entries drain intact.
- Full with pop: a full FIFO that is granted and pushed in the same cycle → count stays DEPTH, no overflow, and the new entry is written DEPTH cycles later.
- Reset mid-drain: reset held low with 3 entries buffered → outputs 0 at once. After reset is released, no writes occur and rr_last=2.
